// File: rtl/rtc_pm_pkg.sv
// Shared constants and helpers for the PM-bus BCD real-time clock.
// Register indices, protocol states, CTRL bits, field widths, month length.
package rtc_pm_pkg;

    localparam logic [3:0] R_S1   = 4'h0;
    localparam logic [3:0] R_S10  = 4'h1;
    localparam logic [3:0] R_MI1  = 4'h2;
    localparam logic [3:0] R_MI10 = 4'h3;
    localparam logic [3:0] R_H1   = 4'h4;
    localparam logic [3:0] R_H10  = 4'h5;
    localparam logic [3:0] R_D1   = 4'h6;
    localparam logic [3:0] R_D10  = 4'h7;
    localparam logic [3:0] R_MO1  = 4'h8;
    localparam logic [3:0] R_MO10 = 4'h9;
    localparam logic [3:0] R_Y1   = 4'hA;
    localparam logic [3:0] R_Y10  = 4'hB;
    localparam logic [3:0] R_W    = 4'hC;
    localparam logic [3:0] R_CTRL = 4'hD;

    localparam int CTRL_HOLD = 0;
    localparam int CTRL_STOP = 1;

    typedef enum logic {ADDR, DATA} state_t;

    function automatic logic [3:0] field_mask(input logic [3:0] idx);
        unique case (idx)
            R_S10, R_MI10, R_W:   field_mask = 4'h7;
            R_H10, R_D10, R_CTRL: field_mask = 4'h3;
            R_MO10:               field_mask = 4'h1;
            4'hE, 4'hF:           field_mask = 4'h0;
            default:              field_mask = 4'hF;
        endcase
    endfunction

    // 10 = 2 (mod 4), so year%4 only needs Y10[0] and Y1[1:0]
    function automatic logic [7:0] month_len(
        input logic [7:0] mo,
        input logic       y10_lsb,
        input logic [1:0] y1_lo
    );
        logic [1:0] ymod;
        ymod = {y10_lsb, 1'b0} + y1_lo;
        unique case (mo)
            8'h02:                      month_len = (ymod == 2'd0) ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: month_len = 8'h30;
            default:                    month_len = 8'h31;
        endcase
    endfunction

endpackage

// File: rtl/rtc_pm_if.sv
// PM nibble-bus strobes from the cartridge side.
// The data nibble is a separate tristate port on the responder.
interface rtc_pm_if;
    logic pmcs1;
    logic pmrd;
    logic pmwr;

    modport master (output pmcs1, pmrd, pmwr);
    modport slave  (input  pmcs1, pmrd, pmwr);
endinterface

// File: rtl/rtc_bcd_clock.sv
// BCD clock core: prescaler, held-second latch, carry chain, register file.
// One write port from the bus side, all 16 nibbles exposed for reads.
module rtc_bcd_clock
    import rtc_pm_pkg::*;
#(
    parameter int CLK_HZ = 16_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [3:0]       widx,
    input  logic [3:0]       wdata,
    output logic [15:0][3:0] rd_bus,
    output logic             sec_ev
);
    localparam int            PW   = $clog2(CLK_HZ);
    localparam logic [PW-1:0] P_TC = PW'(CLK_HZ - 1);

    logic [3:0]    tm [13];
    logic [3:0]    nx [13];
    logic          hold, stop, pending;
    logic [PW-1:0] presc;
    logic          ctrl_we, s1_we, release_ev, adv;
    logic          c_s1, c_s, c_mi1, c_mi, c_h1, c_h;
    logic          c_d1, c_de, c_mo1, c_mo, c_y1;

    assign sec_ev     = !stop && (presc == P_TC);
    assign ctrl_we    = we && (widx == R_CTRL);
    assign s1_we      = we && (widx == R_S1);
    assign release_ev = ctrl_we && !wdata[CTRL_HOLD] && pending;
    assign adv        = (sec_ev && !hold) || release_ev;

    always_comb begin
        c_s1  = tm[R_S1] == 4'd9;
        c_s   = c_s1 && tm[R_S10] == 4'd5;
        c_mi1 = tm[R_MI1] == 4'd9;
        c_mi  = c_s && c_mi1 && tm[R_MI10] == 4'd5;
        c_h1  = tm[R_H1] == 4'd9;
        c_h   = c_mi && tm[R_H10] == 4'd2 && tm[R_H1] == 4'd3;
        c_d1  = tm[R_D1] == 4'd9;
        c_de  = c_h && ({tm[R_D10], tm[R_D1]} == month_len(
                    {tm[R_MO10], tm[R_MO1]}, tm[R_Y10][0], tm[R_Y1][1:0]));
        c_mo1 = tm[R_MO1] == 4'd9;
        c_mo  = c_de && tm[R_MO10] == 4'd1 && tm[R_MO1] == 4'd2;
        c_y1  = tm[R_Y1] == 4'd9;

        nx = tm;
        nx[R_S1] = c_s1 ? 4'd0 : tm[R_S1] + 4'd1;
        if (c_s1) nx[R_S10] = c_s ? 4'd0 : tm[R_S10] + 4'd1;
        if (c_s) begin
            nx[R_MI1] = c_mi1 ? 4'd0 : tm[R_MI1] + 4'd1;
            if (c_mi1) nx[R_MI10] = c_mi ? 4'd0 : tm[R_MI10] + 4'd1;
        end
        if (c_mi) begin
            if (c_h) begin
                nx[R_H1]  = 4'd0;
                nx[R_H10] = 4'd0;
            end else if (c_h1) begin
                nx[R_H1]  = 4'd0;
                nx[R_H10] = tm[R_H10] + 4'd1;
            end else begin
                nx[R_H1] = tm[R_H1] + 4'd1;
            end
        end
        if (c_h) begin
            nx[R_W] = (tm[R_W] == 4'd6) ? 4'd0 : tm[R_W] + 4'd1;
            if (c_de) begin
                nx[R_D1]  = 4'd1;
                nx[R_D10] = 4'd0;
            end else if (c_d1) begin
                nx[R_D1]  = 4'd0;
                nx[R_D10] = tm[R_D10] + 4'd1;
            end else begin
                nx[R_D1] = tm[R_D1] + 4'd1;
            end
        end
        if (c_de) begin
            if (c_mo) begin
                nx[R_MO1]  = 4'd1;
                nx[R_MO10] = 4'd0;
            end else if (c_mo1) begin
                nx[R_MO1]  = 4'd0;
                nx[R_MO10] = 4'd1;
            end else begin
                nx[R_MO1] = tm[R_MO1] + 4'd1;
            end
        end
        if (c_mo) begin
            nx[R_Y1] = c_y1 ? 4'd0 : tm[R_Y1] + 4'd1;
            if (c_y1) nx[R_Y10] = (tm[R_Y10] == 4'd9) ? 4'd0 : tm[R_Y10] + 4'd1;
        end
    end

    // A bus write to a field beats a same-cycle advance of that field
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 13; i++) tm[i] <= 4'h0;
            tm[R_D1]  <= 4'h1;
            tm[R_MO1] <= 4'h1;
            hold      <= 1'b0;
            stop      <= 1'b0;
            pending   <= 1'b0;
            presc     <= '0;
        end else begin
            for (int i = 0; i < 13; i++) begin
                if (we && widx == 4'(i)) tm[i] <= wdata & field_mask(4'(i));
                else if (adv)            tm[i] <= nx[i];
            end
            if (ctrl_we) begin
                hold <= wdata[CTRL_HOLD];
                stop <= wdata[CTRL_STOP];
            end
            if (s1_we || stop || sec_ev) presc <= '0;
            else                         presc <= presc + 1'b1;
            if (s1_we || release_ev)  pending <= 1'b0;
            else if (sec_ev && hold)  pending <= 1'b1;
        end
    end

    always_comb begin
        rd_bus = '0;
        for (int i = 0; i < 13; i++) rd_bus[i] = tm[i];
        rd_bus[R_CTRL] = {2'b00, stop, hold};
    end

endmodule

// File: rtl/rtc_pm_responder.sv
// PM nibble-bus responder: strobe synchronizers, address/data protocol FSM,
// idle timeout and the pmd tristate in front of the BCD clock core.
module rtc_pm_responder
    import rtc_pm_pkg::*;
#(
    parameter int CLK_HZ  = 16_000_000,
    parameter int TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    rtc_pm_if.slave    bus,
    inout  wire  [3:0] pmd,
    output logic       tick
);
    localparam int            TW     = $clog2(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    logic [1:0]       cs_q, rd_q, wr_q;
    logic [3:0]       d_q0, d_q1;
    logic             wr_lvl, rd_lvl, wr_prev, rd_prev;
    logic             wr_ev, rd_end, we, pmd_oe;
    state_t           state;
    logic [3:0]       ptr, rd_data;
    logic [TW-1:0]    tmo;
    logic [15:0][3:0] rd_bus;

    assign wr_lvl = cs_q[1] & wr_q[1];
    assign rd_lvl = cs_q[1] & rd_q[1];
    assign wr_ev  = wr_lvl & ~wr_prev;
    assign rd_end = rd_prev & ~rd_lvl;
    assign we     = wr_ev && (state == DATA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_q    <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            d_q0    <= '0;
            d_q1    <= '0;
            wr_prev <= 1'b0;
            rd_prev <= 1'b0;
        end else begin
            cs_q    <= {cs_q[0], bus.pmcs1};
            rd_q    <= {rd_q[0], bus.pmrd};
            wr_q    <= {wr_q[0], bus.pmwr};
            d_q0    <= pmd;
            d_q1    <= d_q0;
            wr_prev <= wr_lvl;
            rd_prev <= rd_lvl;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ADDR;
            ptr     <= 4'h0;
            tmo     <= '0;
            rd_data <= 4'h0;
        end else begin
            rd_data <= rd_bus[ptr];
            if (wr_ev || rd_end)  tmo <= '0;
            else if (tmo != T_LAST) tmo <= tmo + 1'b1;
            unique case (state)
                ADDR: if (wr_ev) begin
                    ptr   <= d_q1;
                    state <= DATA;
                end
                DATA: if (wr_ev || rd_end || tmo == T_LAST) state <= ADDR;
            endcase
        end
    end

    // Enable straight from the raw strobes so the bus sees data quickly
    assign pmd_oe = bus.pmcs1 & bus.pmrd & (state == DATA);
    assign pmd    = pmd_oe ? rd_data : 4'bzzzz;

    rtc_bcd_clock #(
        .CLK_HZ (CLK_HZ)
    ) u_clock (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .widx   (ptr),
        .wdata  (d_q1),
        .rd_bus (rd_bus),
        .sec_ev (tick)
    );

endmodule

// File: tb/tb_rtc_pm_responder.sv
// Bench for rtc_pm_responder: vector table, calendar model with random
// dates and register traffic, plus hold, timeout and reset sequences.
module tb_rtc_pm_responder;

    localparam int CLK_HZ  = 200;
    localparam int TIMEOUT = 64;

    typedef struct {
        int sec;
        int min;
        int hr;
        int day;
        int mon;
        int yr;
        int wd;
    } tm_t;

    typedef struct {
        logic [3:0] idx;
        logic [3:0] wd;
        logic [3:0] exp;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       tb_oe;
    logic [3:0] tb_d;
    wire  [3:0] pmd;

    int         n_vec = 0;
    int         n_err = 0;
    int         ticks = 0;
    logic [3:0] m [16];

    rtc_pm_if bus_if ();

    assign pmd = tb_oe ? tb_d : 4'bzzzz;

    rtc_pm_responder #(
        .CLK_HZ  (CLK_HZ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus_if),
        .pmd  (pmd),
        .tick (tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) if (tick) ticks <= ticks + 1;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] mmask(input int idx);
        case (idx)
            1, 3, 12: return 4'h7;
            5, 7, 13: return 4'h3;
            9:        return 4'h1;
            14, 15:   return 4'h0;
            default:  return 4'hF;
        endcase
    endfunction

    function automatic int dim(input int mon, input int yr);
        if (mon == 2) return (yr % 4 == 0) ? 29 : 28;
        if (mon == 4 || mon == 6 || mon == 9 || mon == 11) return 30;
        return 31;
    endfunction

    function automatic tm_t next_sec(input tm_t t);
        tm_t r = t;
        r.sec++;
        if (r.sec == 60) begin
            r.sec = 0;
            r.min++;
        end
        if (r.min == 60) begin
            r.min = 0;
            r.hr++;
        end
        if (r.hr == 24) begin
            r.hr = 0;
            r.wd = (r.wd + 1) % 7;
            r.day++;
        end
        if (r.day > dim(r.mon, r.yr)) begin
            r.day = 1;
            r.mon++;
        end
        if (r.mon > 12) begin
            r.mon = 1;
            r.yr = (r.yr + 1) % 100;
        end
        return r;
    endfunction

    function automatic logic [3:0] digit(input tm_t t, input int i);
        case (i)
            0:  return 4'(t.sec % 10);
            1:  return 4'(t.sec / 10);
            2:  return 4'(t.min % 10);
            3:  return 4'(t.min / 10);
            4:  return 4'(t.hr % 10);
            5:  return 4'(t.hr / 10);
            6:  return 4'(t.day % 10);
            7:  return 4'(t.day / 10);
            8:  return 4'(t.mon % 10);
            9:  return 4'(t.mon / 10);
            10: return 4'(t.yr % 10);
            11: return 4'(t.yr / 10);
            12: return 4'(t.wd);
            default: return 4'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m[i] = 4'h0;
        m[6] = 4'h1;
        m[8] = 4'h1;
    endtask

    task automatic bus_wr(input logic [3:0] nib);
        @(negedge clk);
        tb_d = nib;
        tb_oe = 1'b1;
        bus_if.pmcs1 = 1'b1;
        @(negedge clk);
        bus_if.pmwr = 1'b1;
        repeat (4) @(negedge clk);
        bus_if.pmwr = 1'b0;
        @(negedge clk);
        tb_oe = 1'b0;
        bus_if.pmcs1 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic bus_rd(output logic [3:0] d, output logic drv);
        @(negedge clk);
        bus_if.pmcs1 = 1'b1;
        bus_if.pmrd = 1'b1;
        repeat (3) @(negedge clk);
        d = pmd;
        drv = dut.pmd_oe;
        bus_if.pmrd = 1'b0;
        bus_if.pmcs1 = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic put(input int idx, input logic [3:0] d);
        bus_wr(4'(idx));
        bus_wr(d);
        m[idx] = d & mmask(idx);
    endtask

    task automatic get(input int idx, output logic [3:0] d);
        logic drv;
        bus_wr(4'(idx));
        bus_rd(d, drv);
    endtask

    task automatic wait_ticks(input int t0, input int n);
        for (int c = 0; c < (n + 1) * CLK_HZ && ticks < t0 + n; c++)
            @(negedge clk);
    endtask

    task automatic adv_test(input string nm, input tm_t t);
        tm_t        e;
        int         t0;
        logic [3:0] v;
        for (int i = 0; i < 13; i++) put(i, digit(t, i));
        t0 = ticks;
        put(13, 4'h0);
        wait_ticks(t0, 1);
        put(13, 4'h2);
        chk({nm, "_ticks"}, ticks - t0, 1);
        e = next_sec(t);
        for (int i = 0; i < 13; i++) m[i] = digit(e, i);
        for (int i = 0; i < 13; i++) begin
            get(i, v);
            chk($sformatf("%s_r%0d", nm, i), v, m[i]);
        end
    endtask

    initial begin
        vec_t       tbl [14];
        tm_t        t;
        tm_t        e;
        int         t0;
        int         idx;
        logic [3:0] v;
        logic [3:0] d;
        logic       drv;

        tbl[0]  = '{4'hD, 4'h2, 4'h2};
        tbl[1]  = '{4'h5, 4'h2, 4'h2};
        tbl[2]  = '{4'h5, 4'hF, 4'h3};
        tbl[3]  = '{4'h1, 4'hF, 4'h7};
        tbl[4]  = '{4'h3, 4'h9, 4'h1};
        tbl[5]  = '{4'h7, 4'hE, 4'h2};
        tbl[6]  = '{4'h9, 4'hF, 4'h1};
        tbl[7]  = '{4'hC, 4'hF, 4'h7};
        tbl[8]  = '{4'h0, 4'hA, 4'hA};
        tbl[9]  = '{4'hA, 4'hC, 4'hC};
        tbl[10] = '{4'hE, 4'h5, 4'h0};
        tbl[11] = '{4'hF, 4'h9, 4'h0};
        tbl[12] = '{4'hD, 4'hF, 4'h3};
        tbl[13] = '{4'hD, 4'h2, 4'h2};

        rst = 1'b1;
        tb_oe = 1'b0;
        tb_d = 4'h0;
        bus_if.pmcs1 = 1'b0;
        bus_if.pmrd = 1'b0;
        bus_if.pmwr = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        chk("rst_tick", tick, 0);
        chk("rst_oe", dut.pmd_oe, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // address 4 then read, then a stray read with no address
        bus_wr(4'h4);
        bus_rd(v, drv);
        chk("rd_h1", v, 0);
        chk("rd_h1_drv", drv, 1);
        bus_rd(v, drv);
        chk("rd_noaddr_drv", drv, 0);

        for (int k = 0; k < 14; k++) begin
            put(tbl[k].idx, tbl[k].wd);
            get(tbl[k].idx, v);
            chk($sformatf("tbl%0d_r%0h", k, tbl[k].idx), v, tbl[k].exp);
        end

        for (int k = 0; k < 30; k++) begin
            idx = $urandom_range(0, 15);
            d = 4'($urandom_range(0, 15));
            if (idx == 13) d = d | 4'h2;
            put(idx, d);
            idx = $urandom_range(0, 15);
            get(idx, v);
            chk($sformatf("rnd%0d_r%0h", k, idx), v, m[idx]);
        end

        t = '{59, 59, 23, 31, 12, 99, 6};
        adv_test("rollover", t);
        t = '{59, 59, 23, 28, 2, 24, 3};
        adv_test("leap24", t);
        t = '{59, 59, 23, 28, 2, 23, 3};
        adv_test("leap23", t);
        for (int k = 0; k < 5; k++) begin
            t.yr  = $urandom_range(0, 99);
            t.mon = $urandom_range(0, 1) ? 12 : $urandom_range(1, 12);
            t.day = $urandom_range(0, 1) ? dim(t.mon, t.yr)
                                         : $urandom_range(1, dim(t.mon, t.yr));
            t.hr  = $urandom_range(0, 1) ? 23 : $urandom_range(0, 23);
            t.min = $urandom_range(0, 1) ? 59 : $urandom_range(0, 59);
            t.sec = $urandom_range(0, 1) ? 59 : $urandom_range(0, 59);
            t.wd  = $urandom_range(0, 6);
            adv_test($sformatf("rdate%0d", k), t);
        end

        // two seconds under HOLD collapse into one advance on release
        t = '{10, 0, 0, 1, 1, 0, 0};
        for (int i = 0; i < 13; i++) put(i, digit(t, i));
        t0 = ticks;
        put(13, 4'h1);
        wait_ticks(t0, 2);
        put(13, 4'h0);
        put(13, 4'h2);
        chk("hold_ticks", ticks - t0, 2);
        e = next_sec(t);
        get(0, v);
        chk("hold_s1", v, digit(e, 0));
        get(1, v);
        chk("hold_s10", v, digit(e, 1));

        // idle DATA phase times out, next nibble is an address
        put(3, 4'h2);
        put(7, 4'h1);
        bus_wr(4'h3);
        repeat (TIMEOUT + 8) @(negedge clk);
        bus_wr(4'h7);
        bus_rd(v, drv);
        chk("tmo_ptr7", v, m[7]);
        chk("tmo_drv", drv, 1);
        get(3, v);
        chk("tmo_r3", v, m[3]);

        bus_wr(4'h4);
        @(negedge clk);
        bus_if.pmcs1 = 1'b1;
        bus_if.pmrd = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_oe_on", dut.pmd_oe, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_oe", dut.pmd_oe, 0);
        @(negedge clk);
        bus_if.pmrd = 1'b0;
        bus_if.pmcs1 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        get(0, v);
        chk("post_rst_s1", v, m[0]);
        get(8, v);
        chk("post_rst_mo1", v, m[8]);
        get(13, v);
        chk("post_rst_ctrl", v, m[13]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
